// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the maxnet scheduler: FSM state encoding,
// default result width and watchdog counter sizing.
package maxnet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESP    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  localparam int RES_W_DEF = 32;

  // The watchdog only has to count 0..timeout-1.
  function automatic int wd_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping around, returned as a one-hot vector plus its index.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N_REQ);

  logic             found;
  int               cand;
  logic [IDX_W-1:0] cidx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // Candidate index ptr+i reduced modulo N_REQ without a divider.
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cidx = IDX_W'(cand);
      if (!found && req[cidx]) begin
        found     = 1'b1;
        gnt[cidx] = 1'b1;
        gnt_idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/maxnet_sched.sv
// Round-robin scheduler sharing one maxnet engine between N_REQ requesters,
// with a watchdog that aborts and resets a hung engine.
module maxnet_sched
  import maxnet_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024,
  parameter int RES_W   = RES_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic                     resp_valid,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [RES_W-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     busy,
  output logic                     mx_start,
  output logic                     mx_rst,
  input  logic                     mx_done,
  input  logic [RES_W-1:0]         mx_result,
  output state_t                   dbg_state
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  // Handshake: req is a level held by the client until its resp_valid pulse;
  // resp_valid is a single-cycle strobe with no back-pressure, and the
  // engine sees a one-cycle mx_start per grant and answers with mx_done
  // as a level, only honoured while in WAIT.

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [WD_W-1:0]    wd_cnt_q;
  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    mx_start   = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (|req) state_d = ST_START;
      end
      ST_START: begin
        mx_start = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the last watchdog cycle still counts as success.
        if (mx_done)                   state_d = ST_RESP;
        else if (wd_cnt_q == WD_LAST)  state_d = ST_RECOVER;
      end
      ST_RECOVER: state_d = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mx_rst    = rst | (state_q == ST_RECOVER);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      gidx_q    <= '0;
      grant     <= '0;
      wd_cnt_q  <= '0;
      resp_id   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            grant  <= arb_gnt;
            gidx_q <= arb_idx;
          end
        end
        ST_START: wd_cnt_q <= '0;
        ST_WAIT: begin
          wd_cnt_q <= wd_cnt_q + WD_W'(1);
          if (mx_done) begin
            resp_data <= mx_result;
            resp_err  <= 1'b0;
            resp_id   <= gidx_q;
          end
        end
        // Response fields are loaded on the way into RESP so they only
        // change when a new response is presented.
        ST_RECOVER: begin
          resp_data <= '0;
          resp_err  <= 1'b1;
          resp_id   <= gidx_q;
        end
        ST_RESP: begin
          grant <= '0;
          ptr_q <= (gidx_q == IDX_LAST) ? '0 : gidx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_sched.sv
// Self-checking bench for maxnet_sched: table-driven jobs, hand sequences for
// reset/fairness, and randomized jobs against a round-robin reference model.
module tb_maxnet_sched;
  import maxnet_pkg::*;

  localparam int N = 4;
  localparam int T = 16;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   grant;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           busy;
  logic           mx_start;
  logic           mx_rst;
  logic           mx_done = 1'b0;
  logic [W-1:0]   mx_result = '0;
  state_t         dbg_state;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int exp_starts = 0;
  int mptr = 0;

  // scoreboard entries: {err, id, data}
  logic [W+2:0] exp_q[$];

  // engine model knobs
  int           eng_lat = 1;
  logic [W-1:0] eng_res = '0;
  int           eng_cnt = -1;
  logic         eng_start_seen = 1'b0;
  logic         eng_rst_seen = 1'b0;

  maxnet_sched #(.N_REQ(N), .TIMEOUT(T), .RES_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy),
    .mx_start   (mx_start),
    .mx_rst     (mx_rst),
    .mx_done    (mx_done),
    .mx_result  (mx_result),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Registered engine: reacts one cycle after it sees start/reset, leaves
  // done high until the next start or reset, done first high lat cycles
  // after the start cycle (lat==0 means it never finishes).
  always @(negedge clk) begin
    if (eng_rst_seen) begin
      mx_done = 1'b0;
      eng_cnt = -1;
    end else if (eng_start_seen) begin
      mx_done = 1'b0;
      eng_cnt = (eng_lat == 0) ? -1 : eng_lat - 1;
      if (eng_cnt == 0) begin
        mx_done   = 1'b1;
        mx_result = eng_res;
        eng_cnt   = -1;
      end
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        mx_done   = 1'b1;
        mx_result = eng_res;
        eng_cnt   = -1;
      end
    end
    eng_rst_seen   = mx_rst;
    eng_start_seen = mx_start;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (mx_start) start_cnt++;
      chk("grant_onehot0", 64'($onehot0(grant)), 64'(1));
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid), 64'(0));
        end else begin
          logic [W+2:0] e;
          e = exp_q.pop_front();
          chk("resp_id", 64'(resp_id), 64'(e[W+1:W]));
          chk("resp_data", 64'(resp_data), 64'(e[W-1:0]));
          chk("resp_err", 64'(resp_err), 64'(e[W+2]));
        end
      end
    end
  end

  // Reference round-robin: walk the requesters starting at the pointer.
  function automatic int model_pick(input logic [N-1:0] pat, input int p);
    int order[$];
    for (int k = 0; k < N; k++) order.push_back((p + k) % N);
    foreach (order[k]) if (((pat >> order[k]) & 4'd1) != 4'd0) return order[k];
    return -1;
  endfunction

  task automatic do_job(input logic [N-1:0] pat, input int lat, input logic [W-1:0] res,
                        input bit drop, input int exp_id, input logic [W-1:0] exp_data,
                        input logic exp_err);
    int n;
    int rst_at;
    bit got;
    eng_lat = lat;
    eng_res = res;
    @(posedge clk); #1;
    req = pat;
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_grant", 64'(grant), 64'(0));
    exp_q.push_back({exp_err, 2'(exp_id), exp_data});
    exp_starts++;
    @(posedge clk); #1;
    chk("start_grant", 64'(grant), 64'(4'(1) << exp_id));
    chk("start_pulse", 64'(mx_start), 64'(1));
    if (drop) req = req & ~(4'(1) << exp_id);
    n = 0;
    rst_at = -1;
    got = 1'b0;
    while (!got && n < T + 8) begin
      @(posedge clk); #1;
      n++;
      if (mx_rst && rst_at < 0) rst_at = n;
      if (resp_valid) got = 1'b1;
    end
    chk("resp_seen", 64'(got), 64'(1));
    chk("resp_latency", 64'(n), 64'(exp_err ? T + 2 : lat + 1));
    chk("mx_rst_cycle", 64'(rst_at), 64'(exp_err ? T + 1 : -1));
    req = '0;
    mptr = (exp_id + 1) % N;
  endtask

  typedef struct {
    logic [N-1:0] req;
    int           lat;
    logic [W-1:0] res;
    bit           drop;
    int           exp_id;
    logic [W-1:0] exp_data;
    logic         exp_err;
  } vec_t;

  vec_t tbl[8];
  int   fair_ids[5];

  initial begin
    // pointer walk: 0 ->3 ->0 ->1 ->1 ->2 ->1 ->0 ->2
    tbl[0] = '{4'b0100, 10, 32'h0000_00A5, 1'b0, 2, 32'h0000_00A5, 1'b0};
    tbl[1] = '{4'b1111,  3, 32'h0000_1111, 1'b0, 3, 32'h0000_1111, 1'b0};
    tbl[2] = '{4'b1111,  1, 32'h0000_2222, 1'b0, 0, 32'h0000_2222, 1'b0};
    tbl[3] = '{4'b0001,  0, 32'h0000_3333, 1'b0, 0, 32'h0000_0000, 1'b1};
    tbl[4] = '{4'b0011, 16, 32'hDEAD_BEEF, 1'b0, 1, 32'hDEAD_BEEF, 1'b0};
    tbl[5] = '{4'b0011, 17, 32'h0000_4444, 1'b0, 0, 32'h0000_0000, 1'b1};
    tbl[6] = '{4'b1000,  2, 32'h1234_5678, 1'b0, 3, 32'h1234_5678, 1'b0};
    tbl[7] = '{4'b0110,  5, 32'hFFFF_FFFF, 1'b1, 1, 32'hFFFF_FFFF, 1'b0};
    fair_ids = '{0, 1, 2, 3, 0};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_id", 64'(resp_id), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    chk("rst_resp_err", 64'(resp_err), 64'(0));
    chk("rst_mx_start", 64'(mx_start), 64'(0));
    chk("rst_mx_rst", 64'(mx_rst), 64'(1));
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // table-driven jobs (includes stale done left high between jobs)
    for (int i = 0; i < 8; i++)
      do_job(tbl[i].req, tbl[i].lat, tbl[i].res, tbl[i].drop,
             tbl[i].exp_id, tbl[i].exp_data, tbl[i].exp_err);
    chk("hold_resp_id", 64'(resp_id), 64'(1));
    chk("hold_resp_data", 64'(resp_data), 64'(32'hFFFF_FFFF));

    // reset in the middle of WAIT: job abandoned, no response
    eng_lat = 0;
    @(posedge clk); #1;
    req = 4'b0010;
    @(posedge clk); #1;
    chk("rstw_start", 64'(mx_start), 64'(1));
    exp_starts++;
    repeat (3) begin @(posedge clk); #1; end
    chk("rstw_in_wait", 64'(dbg_state), 64'(ST_WAIT));
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_mx_rst", 64'(mx_rst), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstw_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rstw_busy", 64'(busy), 64'(0));
    chk("rstw_grant", 64'(grant), 64'(0));
    chk("rstw_resp_valid", 64'(resp_valid), 64'(0));
    chk("rstw_resp_data", 64'(resp_data), 64'(0));
    mptr = 0;

    // fairness: all four held, served bit dropped for one IDLE cycle;
    // first grant 0 also shows the pointer came back to zero
    begin
      int served;
      int n;
      int sid;
      eng_lat = 3;
      eng_res = 32'hF00D_0001;
      for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 2'(fair_ids[i]), eng_res});
      exp_starts += 5;
      @(posedge clk); #1;
      req = 4'b1111;
      served = 0;
      n = 0;
      while (served < 5 && n < 300) begin
        @(posedge clk); #1;
        n++;
        if (resp_valid) begin
          served++;
          sid = int'(resp_id);
          if (served < 5) begin
            req = req & ~(4'(1) << sid);
            @(posedge clk); #1;
            @(posedge clk); #1;
            n += 2;
            req = req | (4'(1) << sid);
          end else begin
            req = '0;
          end
        end
      end
      chk("fair_served", 64'(served), 64'(5));
      mptr = 1;
    end

    // randomized jobs against the reference model
    for (int i = 0; i < 20; i++) begin
      logic [N-1:0] pat;
      int lat;
      int id;
      logic [W-1:0] res;
      logic err;
      pat = 4'($urandom_range(1, 15));
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 18));
      res = $urandom;
      err = (lat == 0) || (lat > T);
      id  = model_pick(pat, mptr);
      do_job(pat, lat, res, 1'($urandom_range(0, 1)), id, err ? '0 : res, err);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
    chk("start_count", 64'(start_cnt), 64'(exp_starts));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
